// File: rtl/iq_stream_pkg.sv
// Shared types and helpers for the I/Q stream serializer: FSM state,
// lane count and byte reversal used by the optional OUT_BYTE_SWAP_EN build.
package iq_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int SWAP_MAX_W = 128;

  function automatic int lane_count(input int channels);
    return 2 * channels;
  endfunction

  // Reverses the low nbytes bytes of d; upper bytes come back zero.
  function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                       input int nbytes);
    logic [SWAP_MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < SWAP_MAX_W / 8; b++)
      if (b < nbytes) r[b*8 +: 8] = d[(nbytes-1-b)*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/iq_stream_serializer_fifo.sv
// Show-ahead beat FIFO: registered writes, head always visible on data_o.
// A push while full is dropped even if a pop happens in the same cycle.
module iq_beat_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/iq_stream_serializer.sv
// Captures a frame of CHANNELS-wide I/Q beats and serializes them one sample
// per cycle (ch0 I, ch0 Q, ch1 I, ...). Define OUT_BYTE_SWAP_EN for MSB-first bytes.
module iq_stream_serializer
  import iq_stream_pkg::*;
#(
  parameter int CHANNELS  = 1,
  parameter int SAMPLE_W  = 16,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 20460,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         in_valid_i,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_i_i,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_q_i,
  output logic [SAMPLE_W-1:0]          out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o,
  output logic [CNT_W-1:0]             beat_count_o
);

  localparam int LANES = lane_count(CHANNELS);
  localparam int LW    = $clog2(LANES);
  localparam int FCW   = $clog2(DEPTH) + 1;

  state_e                          state_q, state_d;
  logic [LW-1:0]                   lane_q, lane_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            ovf_q, ovf_d;
  logic                            push, pop, flush, hs, lane_last;
  logic                            fifo_full, fifo_empty;
  logic [FCW-1:0]                  fifo_count;
  logic [LANES-1:0][SAMPLE_W-1:0]  beat_in, beat_head;
  logic [SAMPLE_W-1:0]             word, word_out;

  // Interleave I/Q so lane L maps straight onto word L of the stored beat.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_pack
    assign beat_in[2*c]   = in_i_i[c*SAMPLE_W +: SAMPLE_W];
    assign beat_in[2*c+1] = in_q_i[c*SAMPLE_W +: SAMPLE_W];
  end

  iq_beat_fifo #(.WIDTH(LANES*SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (beat_in),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (beat_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o       = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);
  assign out_valid_o  = busy_o && !fifo_empty;
  assign lane_last    = (lane_q == LW'(LANES - 1));
  assign hs           = out_valid_o && out_ready_i;
  assign pop          = hs && lane_last;
  assign out_last_o   = out_valid_o && lane_last && (state_q == ST_DRAIN) &&
                        (fifo_count == FCW'(1));
  assign overflow_o   = ovf_q;
  assign beat_count_o = cnt_q;
  assign word         = beat_head[lane_q];

`ifdef OUT_BYTE_SWAP_EN
  logic [SWAP_MAX_W-1:0] word_sw;
  assign word_sw  = byte_swap(SWAP_MAX_W'(word), SAMPLE_W / 8);
  assign word_out = word_sw[SAMPLE_W-1:0];
`else
  assign word_out = word;
`endif

  // Gate with valid so the bus reads zero when nothing is offered.
  assign out_data_o = out_valid_o ? word_out : '0;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (abort_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      lane_d  = '0;
      flush   = 1'b1;
    end else begin
      if (hs) lane_d = lane_last ? '0 : lane_q + LW'(1);
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
        ST_CAPTURE: if (in_valid_i) begin
          if (!fifo_full) begin
            push  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = ST_DRAIN;
          end else begin
            ovf_d = 1'b1;
          end
        end
        ST_DRAIN: if (hs && out_last_o) state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_iq_stream_serializer.sv
// Randomized bench for iq_stream_serializer with a word-queue reference model.
module tb_iq_stream_serializer;

  localparam int CH = 2;
  localparam int SW = 16;
  localparam int DP = 4;
  localparam int FL = 8;
  localparam int CW = $clog2(FL + 1);
  localparam int LN = 2 * CH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CH*SW-1:0] in_i = '0, in_q = '0;
  logic [SW-1:0]   out_data;
  logic            out_valid, out_last, busy, done, overflow;
  logic [CW-1:0]   beat_count;

  int nvec = 0;
  int nerr = 0;

  // Model: 0 idle, 1 capture, 2 drain, 3 done; FIFO held as a word queue.
  int           m_st = 0;
  logic [SW-1:0] wq[$];
  int           m_bc = 0;
  bit           m_ovf = 1'b0;

  always #5 clk = ~clk;

  iq_stream_serializer #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DP), .FRAME_LEN(FL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .in_valid_i(in_valid), .in_i_i(in_i), .in_q_i(in_q),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .busy_o(busy), .done_o(done),
    .overflow_o(overflow), .beat_count_o(beat_count)
  );

  function automatic logic [SW-1:0] sw(input logic [SW-1:0] w);
`ifdef OUT_BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  function automatic bit m_valid();
    return (m_st == 1 || m_st == 2) && wq.size() > 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit v;
    v = m_valid();
    chk("out_valid", out_valid, v);
    chk("out_data", out_data, v ? sw(wq[0]) : '0);
    chk("out_last", out_last, v && m_st == 2 && wq.size() == 1);
    chk("busy", busy, m_st == 1 || m_st == 2);
    chk("done", done, m_st == 3);
    chk("beat_count", beat_count, m_bc);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic model_step();
    bit hs;
    int beats;
    hs = m_valid() && out_ready;
    if (abort && m_st != 0) begin
      m_st = 0;
      wq.delete();
    end else begin
      case (m_st)
        0: if (start) begin m_st = 1; m_bc = 0; m_ovf = 1'b0; end
        1: begin
          beats = (wq.size() + LN - 1) / LN;
          if (hs) void'(wq.pop_front());
          if (in_valid) begin
            if (beats < DP) begin
              for (int c = 0; c < CH; c++) begin
                wq.push_back(in_i[c*SW +: SW]);
                wq.push_back(in_q[c*SW +: SW]);
              end
              m_bc++;
              if (m_bc == FL) m_st = 2;
            end else m_ovf = 1'b1;
          end
        end
        2: if (hs) begin
          if (wq.size() == 1) m_st = 3;
          void'(wq.pop_front());
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic rnd_cycle(input int pv, input int pr);
    in_valid  = ($urandom_range(0, 99) < pv);
    in_i      = $urandom;
    in_q      = $urandom;
    out_ready = ($urandom_range(0, 99) < pr);
    cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int pv, input int pr, input int budget);
    int n = 0;
    while (m_st != 0 && n < budget) begin
      rnd_cycle(pv, pr);
      n++;
    end
    chk("frame_timeout_busy", busy, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_bc"}, beat_count, 0);
  endtask

  initial begin
    // Reset state
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Ordering: one beat, words must come out A1,A2,B1,B2; in_valid on start cycle ignored
    in_valid = 1'b1;
    in_i = {16'h00B1, 16'h00A1};
    in_q = {16'h00B2, 16'h00A2};
    pulse_start();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("ord0", out_data, sw(16'h00A1));
    cycle(); chk("ord1", out_data, sw(16'h00A2));
    cycle(); chk("ord2", out_data, sw(16'h00B1));
    cycle(); chk("ord3", out_data, sw(16'h00B2));
    run_until_idle(30, 100, 400);

    // Basic frame, sparse input and sink always ready
    pulse_start();
    for (int k = 0; k < FL; k++) begin
      in_valid = 1'b1;
      in_i = {16'h0020 + 16'(k), 16'h0010 + 16'(k)};
      in_q = {16'h8020 + 16'(k), 16'h8010 + 16'(k)};
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
    end
    while (m_st != 0 && nvec < 100000) cycle();
    chk("basic_bc", beat_count, FL);
    chk("basic_ovf", overflow, 0);

    // Overflow: sink stalled, continuous input
    pulse_start();
    out_ready = 1'b0;
    for (int k = 0; k < 2 * DP; k++) begin
      in_valid = 1'b1;
      in_i = $urandom;
      in_q = $urandom;
      cycle();
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_bc", beat_count, DP);
    run_until_idle(50, 100, 400);
    chk("ovf_final_bc", beat_count, FL);

    // Backpressure: out_ready toggles every cycle
    pulse_start();
    out_ready = 1'b0;
    for (int n = 0; n < 400 && m_st != 0; n++) begin
      in_valid  = ($urandom_range(0, 99) < 40);
      in_i      = $urandom;
      in_q      = $urandom;
      out_ready = ~out_ready;
      cycle();
    end
    chk("bp_busy", busy, 0);

    // Abort after two beats, then a clean frame
    pulse_start();
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) rnd_cycle(100, 0);
    in_valid = 1'b0;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bc", beat_count, 2);
    repeat (3) begin cycle(); chk("abort_nodone", done, 0); end
    pulse_start();
    run_until_idle(60, 70, 400);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      pulse_start();
      run_until_idle($urandom_range(20, 100), $urandom_range(20, 100), 600);
    end

    // Reset mid-drain
    pulse_start();
    out_ready = 1'b0;
    for (int n = 0; n < 200 && m_st != 2; n++) rnd_cycle(100, 30);
    out_ready = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    m_st = 0; wq.delete(); m_bc = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    pulse_start();
    run_until_idle(70, 70, 400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/iq_stream_serializer.md
Name: iq_stream_serializer

Overview:
- Parametrised capture-and-serialize stage for transmitter baseband output.
- Accepts beats of CHANNELS parallel I/Q sample pairs, buffers them in a FIFO, and emits one SAMPLE_W word per cycle over a valid/ready stream.
- Word order is ch0 I, ch0 Q, ch1 I, ch1 Q, …
- Stops after a fixed frame of FRAME_LEN beats. Sits between transmitter and the DMA/host sink that produces sample files.

Parameters:
- CHANNELS, 1, number of I/Q channels per input beat (1..8).
- SAMPLE_W, 16, bits per I or Q sample; also the output word width (multiple of 8).
- DEPTH, 8, FIFO depth in input beats (power of 2, >=2).
- FRAME_LEN, 20460, input beats accepted per capture.
- CNT_W, $clog2(FRAME_LEN+1), width of beat_count.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a capture when idle.
- abort  input  1  one-cycle pulse; cancels capture and flushes the FIFO.
- in_valid  input  1  input beat present; there is no in_ready (source cannot stall).
- in_i  input  CHANNELS*SAMPLE_W  I samples; ch0 in the LSBs.
- in_q  input  CHANNELS*SAMPLE_W  Q samples; ch0 in the LSBs.
- out_data  output  SAMPLE_W  current serialized word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts the word.
- out_last  output  1  high with the final word of the frame.
- busy  output  1  high in CAPTURE or DRAIN.
- done  output  1  one-cycle pulse when the frame has fully drained.
- overflow  output  1  sticky; an input beat was dropped because the FIFO was full.
- beat_count  output  CNT_W  beats accepted in the current or last frame.

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, lane index 0; all outputs 0.
- States and transitions:
  - IDLE --start--> CAPTURE. beat_count and overflow are cleared on that edge.
  - CAPTURE: a beat is accepted when in_valid=1 and the FIFO is not full; beat_count increments per accepted beat.
  - CAPTURE: if in_valid=1 and the FIFO is full, the beat is dropped, overflow is set, and beat_count does not change.
  - CAPTURE --(beat_count reaches FRAME_LEN)--> DRAIN. No further beats are accepted.
  - DRAIN --(final word handshaked)--> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. beat_count and overflow hold until the next start.
- start while busy: ignored.
- in_valid in the same cycle as the IDLE start: not accepted; capture begins the following cycle.
- FIFO:
  - Beat width is 2*CHANNELS*SAMPLE_W.
  - Writes are registered; reads are show-ahead.
  - A write into an empty FIFO produces out_valid=1 on the next cycle (latency 1).
- Serializer:
  - A lane index L in 0..2*CHANNELS-1 selects from the FIFO head. Even L gives I of channel L/2; odd L gives Q.
  - out_valid = FIFO not empty and state in {CAPTURE, DRAIN}.
  - On out_valid & out_ready, L advances. At L = 2*CHANNELS-1 it wraps to 0 and the head beat is popped in the same cycle.
  - out_data and out_valid hold steady while out_ready=0.
- Simultaneous push and pop in one cycle is supported. When full, a pop frees a slot one cycle later (a push the same cycle is dropped).
- out_last = out_valid & (L = 2*CHANNELS-1) & (state = DRAIN) & (FIFO count = 1).
- abort (any state except IDLE):
  - Next cycle: IDLE, FIFO flushed, L=0, out_valid=0, no done pulse.
  - overflow and beat_count hold.
- Async reset mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- OUT_BYTE_SWAP_EN defined: each out_data word is byte-reversed (MSB byte first) for big-endian sinks.
- Undefined: words pass through unchanged (little-endian, low byte in bits 7:0).
- Timing and handshakes are identical in both builds.

Decomposition:
- Package iq_stream_pkg holds:
  - state enum typedef (IDLE, CAPTURE, DRAIN, DONE);
  - localparam function for lane count (2*CHANNELS);
  - byte-swap function.
- One sub-module, iq_beat_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, and ports push, pop, flush, full, empty, count.

Test Plan:
1. Basic frame. Config CHANNELS=1, FRAME_LEN=4, out_ready=1. Stimulus: start, then 4 beats with I=16'h0010+k, Q=16'h8010+k. Required: out_data 0010,8010,0011,8011,…,8013; out_last only on the 8th word; done one cycle after it; beat_count=4; overflow=0.
2. Overflow. Config DEPTH=4, FRAME_LEN=8. Stimulus: out_ready=0, continuous in_valid. Required: beats 5+ dropped and overflow=1. Then release out_ready; capture completes with beat_count=8 and output beats are contiguous accepted data.
3. Channel ordering. Config CHANNELS=2. Stimulus: in_i={16'hB1,16'hA1}, in_q={16'hB2,16'hA2}. Required: out_data A1,A2,B1,B2.
4. Backpressure. Stimulus: toggle out_ready every cycle. Required: each word is held until handshaked; no duplicates or losses.
5. Abort. Stimulus: abort after 2 of 4 beats. Required: out_valid=0 the next cycle; IDLE; no done. A following start captures cleanly.
6. Reset and byte swap. Stimulus: reset=0 mid-DRAIN. Required: all outputs 0 immediately. With OUT_BYTE_SWAP_EN, input I=16'h1234 emits 16'h3412.
